// File: rtl/seven_seg_scan_controller.sv
// Four-digit multiplexed seven-segment scan controller.
// Each digit slot is GUARD anode-off cycles followed by ON_TIME anode-on
// cycles. A new value is staged in a pending register and swapped into
// the display register only at the start of a frame, so a frame never
// mixes digits from two different values.
module seven_seg_scan_controller #(
    parameter int GUARD   = 8,
    parameter int ON_TIME = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] d,
    input  logic [3:0]  blank,
    input  logic        lzs,
    output logic        x3,
    output logic        x2,
    output logic        x1,
    output logic        x0,
    output logic [3:0]  an,
    output logic        ack
);

    localparam int MAXC = (GUARD > ON_TIME) ? GUARD : ON_TIME;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_TIME - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GUARD,
        ST_ON
    } state_t;

    state_t        state;
    logic [1:0]    dig;
    logic [CW-1:0] cnt;
    logic [15:0]   disp;
    logic [15:0]   pend;
    logic          pv;
    logic [3:0]    xr;
    logic [3:0]    supp;
    logic [3:0]    on_an;
    logic [1:0]    dig_nxt;

    assign {x3, x2, x1, x0} = xr;
    assign dig_nxt = dig + 2'd1;

    // Per-digit suppression: blanking, or leading zero when every nibble
    // from this digit upward is zero. Digit 0 is never zero-suppressed.
    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_supp
            if (k == 0) begin : g_d0
                assign supp[k] = blank[k];
            end else begin : g_dk
                assign supp[k] = blank[k] | (lzs & ~|disp[15:4*k]);
            end
        end
    endgenerate

    // Anode pattern for the currently scanned digit while in its on-window.
    assign on_an = supp[dig] ? 4'hF : ~(4'b0001 << dig);

    function automatic logic [3:0] nib(input logic [15:0] v, input logic [1:0] idx);
        return v[{idx, 2'b00} +: 4];
    endfunction

    // Scan state machine with registered anode, nibble and ack outputs.
    always_ff @(posedge clk) begin
        ack <= 1'b0;
        if (reset) begin
            state <= ST_IDLE;
            dig   <= 2'd0;
            cnt   <= '0;
            disp  <= 16'h0000;
            pend  <= 16'h0000;
            pv    <= 1'b0;
            an    <= 4'hF;
            xr    <= 4'h0;
        end else begin
            if (load) begin
                pend <= d;
                pv   <= 1'b1;
            end
            if (!enable) begin
                state <= ST_IDLE;
                dig   <= 2'd0;
                cnt   <= '0;
                an    <= 4'hF;
            end else begin
                case (state)
                    ST_GUARD: begin
                        an <= 4'hF;
                        if (cnt == GUARD_LAST) begin
                            state <= ST_ON;
                            cnt   <= '0;
                            an    <= on_an;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ST_ON: begin
                        an <= on_an;
                        if (cnt != ON_LAST) begin
                            cnt <= cnt + CW'(1);
                        end else begin
                            state <= ST_GUARD;
                            cnt   <= '0;
                            an    <= 4'hF;
                            dig   <= dig_nxt;
                            xr    <= nib(disp, dig_nxt);
                        end
                    end
                    default: begin
                        state <= ST_GUARD;
                        cnt   <= '0;
                        an    <= 4'hF;
                        dig   <= 2'd0;
                        xr    <= disp[3:0];
                    end
                endcase
                // Frame start: from IDLE, or leaving the last on-cycle of digit 3.
                // A load on this very edge bypasses the pending register.
                if (state == ST_IDLE || (state == ST_ON && dig == 2'd3 && cnt == ON_LAST)) begin
                    if (load) begin
                        disp <= d;
                        pv   <= 1'b0;
                        ack  <= 1'b1;
                        xr   <= d[3:0];
                    end else if (pv) begin
                        disp <= pend;
                        pv   <= 1'b0;
                        ack  <= 1'b1;
                        xr   <= pend[3:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Directed bench for the scan controller with GUARD=2, ON_TIME=4, so one
// slot is 6 cycles and one frame 24. Inputs change and outputs are
// sampled on the falling edge; frame position 0 is the first cycle after
// the edge that enters GUARD_0.
module tb_seven_seg_scan_controller;

    logic        clk = 1'b0;
    logic        reset, enable, load, lzs;
    logic [15:0] d;
    logic [3:0]  blank;
    logic        x3, x2, x1, x0;
    logic [3:0]  an;
    logic        ack;
    int          checks = 0;
    int          errors = 0;

    seven_seg_scan_controller #(.GUARD(2), .ON_TIME(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .d(d),
        .blank(blank), .lzs(lzs), .x3(x3), .x2(x2), .x1(x1), .x0(x0),
        .an(an), .ack(ack)
    );

    always #5 clk = ~clk;

    // Expected anodes at frame position pos given which digits should light.
    function automatic logic [3:0] exp_an(input int pos, input logic [3:0] lit);
        int s;
        s = pos / 6;
        if ((pos % 6) < 2 || !lit[s]) return 4'hF;
        return ~(4'b0001 << s);
    endfunction

    function automatic logic [3:0] exp_x(input int pos, input logic [15:0] v);
        logic [15:0] t;
        t = v >> (4 * (pos / 6));
        return t[3:0];
    endfunction

    task automatic test_reset;
        reset = 1'b1; enable = 1'b0; load = 1'b0; d = 16'h0; blank = 4'h0; lzs = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got=%b exp=1111", an); end
        checks++; if ({x3, x2, x1, x0} !== 4'h0) begin errors++; $display("FAIL reset_x got=%b exp=0000", {x3, x2, x1, x0}); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", ack); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL idle_an got=%b exp=1111", an); end
    endtask

    // Scenario 1: load 1234h, enable, two full frames.
    task automatic test_scan_basic;
        int acks = 0;
        load = 1'b1; d = 16'h1234;
        @(negedge clk);
        load = 1'b0; enable = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 48; c++) begin
            if (ack) acks++;
            checks++; if (an !== exp_an(c % 24, 4'hF)) begin errors++; $display("FAIL basic_an c=%0d got=%b exp=%b", c, an, exp_an(c % 24, 4'hF)); end
            checks++; if ({x3, x2, x1, x0} !== exp_x(c % 24, 16'h1234)) begin errors++; $display("FAIL basic_x c=%0d got=%h exp=%h", c, {x3, x2, x1, x0}, exp_x(c % 24, 16'h1234)); end
            checks++; if (ack !== (c == 0)) begin errors++; $display("FAIL basic_ack c=%0d got=%b", c, ack); end
            @(negedge clk);
        end
        checks++; if (acks != 1) begin errors++; $display("FAIL basic_ack_count got=%0d exp=1", acks); end
    endtask

    // Scenario 2: load ABCDh in ON_1; old value holds until next frame.
    task automatic test_commit_midframe;
        int acks = 0;
        for (int c = 0; c < 10; c++) @(negedge clk);
        load = 1'b1; d = 16'hABCD;
        @(negedge clk);
        load = 1'b0; d = 16'h0;
        for (int c = 11; c < 48; c++) begin
            logic [15:0] v;
            v = (c < 24) ? 16'h1234 : 16'hABCD;
            if (ack) acks++;
            checks++; if (an !== exp_an(c % 24, 4'hF)) begin errors++; $display("FAIL mid_an c=%0d got=%b exp=%b", c, an, exp_an(c % 24, 4'hF)); end
            checks++; if ({x3, x2, x1, x0} !== exp_x(c % 24, v)) begin errors++; $display("FAIL mid_x c=%0d got=%h exp=%h", c, {x3, x2, x1, x0}, exp_x(c % 24, v)); end
            checks++; if (ack !== (c == 24)) begin errors++; $display("FAIL mid_ack c=%0d got=%b", c, ack); end
            @(negedge clk);
        end
        checks++; if (acks != 1) begin errors++; $display("FAIL mid_ack_count got=%0d exp=1", acks); end
    endtask

    // Scenario 5: enable drops in ON_2, then restart at GUARD_0 with no commit.
    task automatic test_enable_drop;
        int acks = 0;
        for (int c = 0; c < 15; c++) @(negedge clk);
        checks++; if (an !== 4'b1011) begin errors++; $display("FAIL drop_pre_an got=%b exp=1011", an); end
        enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (an !== 4'hF) begin errors++; $display("FAIL drop_an c=%0d got=%b exp=1111", c, an); end
        end
        enable = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 24; c++) begin
            if (ack) acks++;
            checks++; if (an !== exp_an(c, 4'hF)) begin errors++; $display("FAIL reen_an c=%0d got=%b exp=%b", c, an, exp_an(c, 4'hF)); end
            checks++; if ({x3, x2, x1, x0} !== exp_x(c, 16'hABCD)) begin errors++; $display("FAIL reen_x c=%0d got=%h exp=%h", c, {x3, x2, x1, x0}, exp_x(c, 16'hABCD)); end
            @(negedge clk);
        end
        checks++; if (acks != 0) begin errors++; $display("FAIL reen_ack_count got=%0d exp=0", acks); end
    endtask

    // Scenario 3: 0007h with leading-zero suppression on, then off.
    task automatic test_lzs;
        enable = 1'b0; load = 1'b1; d = 16'h0007; lzs = 1'b1;
        @(negedge clk);
        load = 1'b0; d = 16'h0; enable = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 48; c++) begin
            logic [3:0] lit;
            if (c == 24) lzs = 1'b0;
            lit = (c < 24) ? 4'b0001 : 4'b1111;
            checks++; if (an !== exp_an(c % 24, lit)) begin errors++; $display("FAIL lzs_an c=%0d got=%b exp=%b", c, an, exp_an(c % 24, lit)); end
            checks++; if ({x3, x2, x1, x0} !== exp_x(c % 24, 16'h0007)) begin errors++; $display("FAIL lzs_x c=%0d got=%h exp=%h", c, {x3, x2, x1, x0}, exp_x(c % 24, 16'h0007)); end
            checks++; if (ack !== (c == 0)) begin errors++; $display("FAIL lzs_ack c=%0d got=%b", c, ack); end
            @(negedge clk);
        end
    endtask

    // Scenario 4: digit 2 blanked; load lands exactly on the commit edge.
    task automatic test_blank_and_edge_load;
        int acks = 0;
        blank = 4'b0100;
        for (int c = 0; c < 72; c++) begin
            logic [15:0] v;
            v = (c < 24) ? 16'h0007 : 16'h5A5A;
            if (c == 23) begin load = 1'b1; d = 16'h5A5A; end
            if (c == 24) begin load = 1'b0; d = 16'h0; end
            if (ack) acks++;
            checks++; if (an !== exp_an(c % 24, 4'b1011)) begin errors++; $display("FAIL blank_an c=%0d got=%b exp=%b", c, an, exp_an(c % 24, 4'b1011)); end
            checks++; if ({x3, x2, x1, x0} !== exp_x(c % 24, v)) begin errors++; $display("FAIL blank_x c=%0d got=%h exp=%h", c, {x3, x2, x1, x0}, exp_x(c % 24, v)); end
            checks++; if (ack !== (c == 24)) begin errors++; $display("FAIL blank_ack c=%0d got=%b", c, ack); end
            @(negedge clk);
        end
        checks++; if (acks != 1) begin errors++; $display("FAIL edge_ack_count got=%0d exp=1", acks); end
    endtask

    // Scenario 6: reset in ON_1 with a pending value; nothing survives.
    task automatic test_reset_mid_slot;
        int acks = 0;
        for (int c = 0; c < 3; c++) @(negedge clk);
        load = 1'b1; d = 16'h9999;
        @(negedge clk);
        load = 1'b0;
        for (int c = 4; c < 9; c++) @(negedge clk);
        checks++; if (an !== 4'b1101) begin errors++; $display("FAIL rst_pre_an got=%b exp=1101", an); end
        reset = 1'b1; load = 1'b1; d = 16'hFFFF;
        @(negedge clk);
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL rst_an got=%b exp=1111", an); end
        checks++; if ({x3, x2, x1, x0} !== 4'h0) begin errors++; $display("FAIL rst_x got=%h exp=0", {x3, x2, x1, x0}); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0", ack); end
        reset = 1'b0; load = 1'b0; d = 16'h0;
        @(negedge clk);
        for (int c = 0; c < 24; c++) begin
            if (ack) acks++;
            checks++; if (an !== exp_an(c, 4'b1011)) begin errors++; $display("FAIL post_rst_an c=%0d got=%b exp=%b", c, an, exp_an(c, 4'b1011)); end
            checks++; if ({x3, x2, x1, x0} !== 4'h0) begin errors++; $display("FAIL post_rst_x c=%0d got=%h exp=0", c, {x3, x2, x1, x0}); end
            @(negedge clk);
        end
        checks++; if (acks != 0) begin errors++; $display("FAIL post_rst_ack_count got=%0d exp=0", acks); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_scan_basic();
        test_commit_midframe();
        test_enable_drop();
        test_lzs();
        test_blank_and_edge_load();
        test_reset_mid_slot();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
